// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage and its pipeline neighbours (decode/exec),
// plus the instruction-memory image used by fetch.
package fetch_unit_pkg;

  localparam int          DBITS_DEF        = 32;
  localparam logic [31:0] INSTSIZE_DEF     = 32'd4;
  localparam logic [31:0] STARTPC_DEF      = 32'h0000_0100;
  localparam int          IMEMADDRBITS_DEF = 16;
  localparam int          IMEMWORDBITS_DEF = 2;
  localparam int          IMEMWIDX_DEF     = IMEMADDRBITS_DEF - IMEMWORDBITS_DEF;
  localparam int          BTBBITS_DEF      = 6;

  typedef enum logic [3:0] {
    OP1_ALUR = 4'b0000,
    OP1_ALUI = 4'b1000,
    OP1_LW   = 4'b1001,
    OP1_SW   = 4'b0101,
    OP1_BEQ  = 4'b0010,
    OP1_JAL  = 4'b1011
  } op1_e;

  localparam logic [7:0] OP2_ADD = 8'b0010_0000;
  localparam logic [7:0] OP2_SUB = 8'b0010_1000;
  localparam logic [7:0] OP2_AND = 8'b0010_0100;
  localparam logic [7:0] OP2_OR  = 8'b0010_0101;

  // Instruction ROM image: each word carries its own word index so every fetch is distinguishable.
  function automatic logic [31:0] imem_word(input logic [IMEMWIDX_DEF-1:0] widx);
    return {8'hE5, 2'b00, widx, 8'h3C};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage boundary: stall/redirect/training in from decode and exec, D register out.
interface fetch_unit_if import fetch_unit_pkg::*; #(
  parameter int DBITS = DBITS_DEF
);
  logic             stall;
  logic             mispred_B;
  logic [DBITS-1:0] pcgood_B;
  logic             bupd_A;
  logic [DBITS-1:0] bupd_pc_A;
  logic [DBITS-1:0] bupd_targ_A;
  logic             bupd_taken_A;
  logic [DBITS-1:0] inst_D;
  logic [DBITS-1:0] pcplus_D;
  logic [DBITS-1:0] pcpred_D;
  logic             isnop_D;

  modport slave (
    input  stall, mispred_B, pcgood_B, bupd_A, bupd_pc_A, bupd_targ_A, bupd_taken_A,
    output inst_D, pcplus_D, pcpred_D, isnop_D
  );

  modport master (
    output stall, mispred_B, pcgood_B, bupd_A, bupd_pc_A, bupd_targ_A, bupd_taken_A,
    input  inst_D, pcplus_D, pcpred_D, isnop_D
  );
endinterface

// File: rtl/fetch_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational, so a same-cycle update is only seen from the next cycle.
module fetch_btb import fetch_unit_pkg::*; #(
  parameter int DBITS        = DBITS_DEF,
  parameter int BTBBITS      = BTBBITS_DEF,
  parameter int IMEMADDRBITS = IMEMADDRBITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] lookup_pc,
  output logic             lookup_hit,
  output logic             lookup_taken,
  output logic [DBITS-1:0] lookup_target,
  input  logic             upd_en,
  input  logic [DBITS-1:0] upd_pc,
  input  logic [DBITS-1:0] upd_targ,
  input  logic             upd_taken
);
  localparam int ENTRIES = 1 << BTBBITS;
  localparam int TAGBITS = IMEMADDRBITS - BTBBITS - 2;

  logic [ENTRIES-1:0] valid_r;
  logic [TAGBITS-1:0] tag_r  [ENTRIES];
  logic [DBITS-1:0]   targ_r [ENTRIES];
  logic [1:0]         ctr_r  [ENTRIES];

  logic [BTBBITS-1:0] rd_idx_s;
  logic [BTBBITS-1:0] wr_idx_s;
  logic [TAGBITS-1:0] rd_tag_s;
  logic [TAGBITS-1:0] wr_tag_s;
  logic               wr_hit_s;
  logic [1:0]         ctr_old_s;
  logic [1:0]         ctr_next_s;
  logic               unused_s;

  assign rd_idx_s = lookup_pc[BTBBITS+1:2];
  assign rd_tag_s = lookup_pc[IMEMADDRBITS-1:BTBBITS+2];
  assign wr_idx_s = upd_pc[BTBBITS+1:2];
  assign wr_tag_s = upd_pc[IMEMADDRBITS-1:BTBBITS+2];
  assign unused_s = ^{lookup_pc[DBITS-1:IMEMADDRBITS], lookup_pc[1:0],
                      upd_pc[DBITS-1:IMEMADDRBITS], upd_pc[1:0]};

  assign lookup_hit    = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s);
  assign lookup_taken  = (ctr_r[rd_idx_s] >= 2'd2);
  assign lookup_target = targ_r[rd_idx_s];

  assign wr_hit_s  = valid_r[wr_idx_s] && (tag_r[wr_idx_s] == wr_tag_s);
  assign ctr_old_s = ctr_r[wr_idx_s];

  // Saturating counter step in the resolved direction.
  always_comb begin
    ctr_next_s = ctr_old_s;
    if (upd_taken) begin
      if (ctr_old_s != 2'd3) ctr_next_s = ctr_old_s + 2'd1;
      else                   ctr_next_s = ctr_old_s;
    end else begin
      if (ctr_old_s != 2'd0) ctr_next_s = ctr_old_s - 2'd1;
      else                   ctr_next_s = ctr_old_s;
    end
  end

  // Valid bits: cleared by reset, set when a taken miss allocates an entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= {ENTRIES{1'b0}};
    end else if (upd_en && upd_taken && !wr_hit_s) begin
      valid_r[wr_idx_s] <= 1'b1;
    end
  end

  // Tag/target/counter storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (!reset && upd_en) begin
      if (wr_hit_s) begin
        ctr_r[wr_idx_s] <= ctr_next_s;
        if (upd_taken) targ_r[wr_idx_s] <= upd_targ;
      end else if (upd_taken) begin
        tag_r[wr_idx_s]  <= wr_tag_s;
        targ_r[wr_idx_s] <= upd_targ;
        ctr_r[wr_idx_s]  <= 2'd2;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, instruction ROM read, BTB next-PC prediction,
// and the fetch/decode pipeline register.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter int          DBITS        = DBITS_DEF,
  parameter logic [31:0] INSTSIZE     = INSTSIZE_DEF,
  parameter logic [31:0] STARTPC      = STARTPC_DEF,
  parameter int          IMEMADDRBITS = IMEMADDRBITS_DEF,
  parameter int          IMEMWORDBITS = IMEMWORDBITS_DEF,
  parameter int          BTBBITS      = BTBBITS_DEF
) (
  input logic         clk,
  input logic         reset,
  fetch_unit_if.slave bus
);
  logic [DBITS-1:0] pc_r;
  logic [DBITS-1:0] pcplus_s;
  logic [DBITS-1:0] pcpred_s;
  logic [DBITS-1:0] inst_s;
  logic [DBITS-1:0] btb_target_s;
  logic             btb_hit_s;
  logic             btb_taken_s;

  logic [DBITS-1:0] inst_d_r;
  logic [DBITS-1:0] pcplus_d_r;
  logic [DBITS-1:0] pcpred_d_r;
  logic             isnop_d_r;

  assign pcplus_s = pc_r + DBITS'(INSTSIZE);
  assign inst_s   = DBITS'(imem_word(pc_r[IMEMADDRBITS-1:IMEMWORDBITS]));

  fetch_btb #(
    .DBITS        (DBITS),
    .BTBBITS      (BTBBITS),
    .IMEMADDRBITS (IMEMADDRBITS)
  ) u_btb (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc     (pc_r),
    .lookup_hit    (btb_hit_s),
    .lookup_taken  (btb_taken_s),
    .lookup_target (btb_target_s),
    .upd_en        (bus.bupd_A),
    .upd_pc        (bus.bupd_pc_A),
    .upd_targ      (bus.bupd_targ_A),
    .upd_taken     (bus.bupd_taken_A)
  );

  // Predicted next PC: BTB target only on a hit with a taken-leaning counter.
  always_comb begin
    pcpred_s = pcplus_s;
    if (btb_hit_s && btb_taken_s) pcpred_s = btb_target_s;
    else                          pcpred_s = pcplus_s;
  end

  // PC and D register; a redirect overrides a decode stall and inserts a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r       <= DBITS'(STARTPC);
      isnop_d_r  <= 1'b1;
      inst_d_r   <= {DBITS{1'b0}};
      pcplus_d_r <= {DBITS{1'b0}};
      pcpred_d_r <= {DBITS{1'b0}};
    end else if (bus.mispred_B) begin
      pc_r      <= bus.pcgood_B;
      isnop_d_r <= 1'b1;
    end else if (!bus.stall) begin
      pc_r       <= pcpred_s;
      inst_d_r   <= inst_s;
      pcplus_d_r <= pcplus_s;
      pcpred_d_r <= pcpred_s;
      isnop_d_r  <= 1'b0;
    end
  end

  assign bus.inst_D   = inst_d_r;
  assign bus.pcplus_D = pcplus_d_r;
  assign bus.pcpred_D = pcpred_d_r;
  assign bus.isnop_D  = isnop_d_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a behavioural model queues the expected D register
// per edge, plus directed spot checks against hand-derived constants.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pcplus;
    logic [31:0] pcpred;
    logic        isnop;
    logic        data_valid;
  } dexp_t;

  dexp_t       sb_q[$];
  dexp_t       m_d;
  logic [31:0] m_pc;
  logic        m_valid [64];
  logic [7:0]  m_tag   [64];
  logic [31:0] m_targ  [64];
  logic [1:0]  m_ctr   [64];
  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] pc);
    return 32'hE500_003C | ({18'd0, pc[15:2]} << 8);
  endfunction

  function automatic logic [31:0] predict(input logic [31:0] pc);
    int i;
    i = int'(pc[7:2]);
    if (m_valid[i] && (m_tag[i] == pc[15:8]) && (m_ctr[i] >= 2'd2)) return m_targ[i];
    return pc + 32'd4;
  endfunction

  task automatic set_in(input logic st, input logic mp, input logic [31:0] good,
                        input logic bu, input logic [31:0] bpc, input logic [31:0] btg,
                        input logic bt);
    bus.stall        = st;
    bus.mispred_B    = mp;
    bus.pcgood_B     = good;
    bus.bupd_A       = bu;
    bus.bupd_pc_A    = bpc;
    bus.bupd_targ_A  = btg;
    bus.bupd_taken_A = bt;
  endtask

  // One clock: predict D from the model, push it, clock, then pop and compare.
  task automatic tick();
    dexp_t       nd;
    dexp_t       e;
    logic [31:0] npc;
    int          i;
    nd  = m_d;
    npc = m_pc;
    if (reset) begin
      npc = 32'h100;
      nd  = '{inst: 32'd0, pcplus: 32'd0, pcpred: 32'd0, isnop: 1'b1, data_valid: 1'b1};
      for (int k = 0; k < 64; k++) m_valid[k] = 1'b0;
    end else begin
      if (bus.mispred_B) begin
        npc           = bus.pcgood_B;
        nd.isnop      = 1'b1;
        nd.data_valid = 1'b0;
      end else if (!bus.stall) begin
        npc = predict(m_pc);
        nd  = '{inst: rom_word(m_pc), pcplus: m_pc + 32'd4, pcpred: npc,
                isnop: 1'b0, data_valid: 1'b1};
      end
      if (bus.bupd_A) begin
        i = int'(bus.bupd_pc_A[7:2]);
        if (m_valid[i] && (m_tag[i] == bus.bupd_pc_A[15:8])) begin
          if (bus.bupd_taken_A) begin
            m_targ[i] = bus.bupd_targ_A;
            if (m_ctr[i] != 2'd3) m_ctr[i] = m_ctr[i] + 2'd1;
          end else if (m_ctr[i] != 2'd0) begin
            m_ctr[i] = m_ctr[i] - 2'd1;
          end
        end else if (bus.bupd_taken_A) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = bus.bupd_pc_A[15:8];
          m_targ[i]  = bus.bupd_targ_A;
          m_ctr[i]   = 2'd2;
        end
      end
    end
    sb_q.push_back(nd);
    @(posedge clk);
    m_pc = npc;
    m_d  = nd;
    @(negedge clk);
    e = sb_q.pop_front();
    check_eq("isnop_D", {31'd0, bus.isnop_D}, {31'd0, e.isnop});
    if (e.data_valid) begin
      check_eq("inst_D",   bus.inst_D,   e.inst);
      check_eq("pcplus_D", bus.pcplus_D, e.pcplus);
      check_eq("pcpred_D", bus.pcpred_D, e.pcpred);
    end
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Redirect to pc, then let it be fetched so D holds the instruction at pc.
  task automatic redirect(input logic [31:0] pc);
    set_in(1'b0, 1'b1, pc, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    idle();
    tick();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (3) tick();
    check_eq("rst_pcpred", bus.pcpred_D, 32'h0);
    reset = 1'b0;
    check_eq("rel_isnop", {31'd0, bus.isnop_D}, 32'd1);
    tick();
    check_eq("first_inst",   bus.inst_D,   32'hE500_403C);
    check_eq("first_pcplus", bus.pcplus_D, 32'h104);
    check_eq("first_pcpred", bus.pcpred_D, 32'h104);
    tick();

    set_in(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    check_eq("stall_pcplus", bus.pcplus_D, 32'h108);
    idle();
    tick();
    tick();
    check_eq("resume_pcplus", bus.pcplus_D, 32'h110);

    set_in(1'b1, 1'b1, 32'h200, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    check_eq("mispred_isnop", {31'd0, bus.isnop_D}, 32'd1);
    idle();
    tick();
    check_eq("redir_inst",   bus.inst_D,   32'hE500_803C);
    check_eq("redir_pcplus", bus.pcplus_D, 32'h204);

    set_in(1'b0, 1'b0, 32'd0, 1'b1, 32'h120, 32'h100, 1'b1);
    tick();
    idle();
    redirect(32'h120);
    check_eq("trained_pred", bus.pcpred_D, 32'h100);

    set_in(1'b0, 1'b0, 32'd0, 1'b1, 32'h120, 32'h100, 1'b0);
    tick();
    tick();
    idle();
    redirect(32'h120);
    check_eq("untrained_pred", bus.pcpred_D, 32'h124);

    set_in(1'b0, 1'b0, 32'd0, 1'b1, 32'h120, 32'h100, 1'b1);
    repeat (5) tick();
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 32'h120, 32'h100, 1'b0);
    tick();
    idle();
    redirect(32'h120);
    check_eq("sat_pred", bus.pcpred_D, 32'h100);

    set_in(1'b0, 1'b1, 32'h120, 1'b0, 32'd0, 32'd0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 32'h120, 32'h100, 1'b0);
    tick();
    check_eq("same_cycle_old", bus.pcpred_D, 32'h100);
    idle();
    redirect(32'h120);
    check_eq("same_cycle_new", bus.pcpred_D, 32'h124);

    set_in(1'b0, 1'b0, 32'd0, 1'b1, 32'h100, 32'h300, 1'b1);
    tick();
    idle();
    redirect(32'h100);
    check_eq("pre_reset_pred", bus.pcpred_D, 32'h300);
    reset = 1'b1;
    set_in(1'b0, 1'b1, 32'h240, 1'b1, 32'h100, 32'h300, 1'b1);
    tick();
    tick();
    check_eq("midrst_isnop", {31'd0, bus.isnop_D}, 32'd1);
    reset = 1'b0;
    idle();
    tick();
    check_eq("post_rst_pcplus", bus.pcplus_D, 32'h104);
    check_eq("post_rst_pred",   bus.pcpred_D, 32'h104);

    for (int n = 0; n < 60; n++) begin
      set_in($urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0,
             32'h100 + (32'($urandom_range(0, 31)) << 2),
             $urandom_range(0, 2) == 0,
             32'h100 + (32'($urandom_range(0, 15)) << 2),
             32'h100 + (32'($urandom_range(0, 31)) << 2),
             1'($urandom_range(0, 1)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
